pwm_multi: RTL and testbench

Multi-channel PWM generator sharing one period counter across `CHANNELS` outputs, with parametrised counter width. Supports edge-aligned and center-aligned modes, plus double-buffered period/duty/mode registers that take effect only at a period boundary. Sits between the control registers (servo/motor controllers) and the output pins. Successor to the single-channel fixed-32-bit PWM.

---
 rtl/pwm_multi.sv | 128 ++++++++++++
 tb/tb_pwm_multi.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pwm_multi.sv
// pwm_multi: multi-channel PWM generator. All channels share one period
// counter. Edge-aligned and center-aligned modes are supported. Period, duty
// and mode registers are double-buffered and only change at a period boundary.
//
// Ports:
//   clk          rising-edge clock
//   rst          asynchronous active-high reset
//   enable       run the counter; low holds cnt at 0 and outputs low
//   period       requested period P
//   duty         requested duties, channel i at [i*WIDTH +: WIDTH]
//   center       requested mode (0 edge-aligned, 1 center-aligned)
//   update       one-cycle strobe that captures period/duty/center
//   pending      staged values are waiting for a boundary
//   cycle_start  pulse on the first output sample of each period
//   pwm_out      registered PWM outputs
//
// Counter direction state:
//   state    | meaning
//   DIR_UP   | counting 0 -> P-1 (the only direction used in edge mode)
//   DIR_DOWN | counting P-2 -> 1 in center mode
module pwm_multi #(
   parameter int WIDTH    = 16,
   parameter int CHANNELS = 4
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      enable,
   input  logic [WIDTH-1:0]          period,
   input  logic [CHANNELS*WIDTH-1:0] duty,
   input  logic                      center,
   input  logic                      update,
   output logic                      pending,
   output logic                      cycle_start,
   output logic [CHANNELS-1:0]       pwm_out
);

   typedef enum logic {DIR_UP = 1'b0, DIR_DOWN = 1'b1} dir_t;

   localparam logic [WIDTH-1:0] ONE = WIDTH'(1);
   localparam logic [WIDTH-1:0] TWO = WIDTH'(2);

   logic [WIDTH-1:0]          cnt, cnt_next;
   dir_t                      dir, dir_next;
   logic [WIDTH-1:0]          a_period, s_period;
   logic [CHANNELS*WIDTH-1:0] a_duty, s_duty;
   logic                      a_center, s_center;
   logic                      boundary;
   logic [CHANNELS-1:0]       pwm_next;

   always_comb begin
      boundary = !enable || (a_period <= ONE)
              || (!a_center && (cnt >= a_period - ONE))
              || (a_center && (dir == DIR_DOWN) && (cnt <= ONE));

      cnt_next = cnt;
      dir_next = dir;
      if (!enable || (a_period <= ONE)) begin
         cnt_next = '0;
         dir_next = DIR_UP;
      end else if (!a_center) begin
         // ">=" rather than "==" so an out-of-range count still wraps
         cnt_next = boundary ? '0 : cnt + ONE;
         dir_next = DIR_UP;
      end else if (dir == DIR_UP) begin
         if (cnt >= a_period - ONE) begin
            cnt_next = a_period - TWO;
            dir_next = DIR_DOWN;
         end else begin
            cnt_next = cnt + ONE;
         end
      end else if (cnt <= ONE) begin
         cnt_next = '0;
         dir_next = DIR_UP;
      end else begin
         cnt_next = cnt - ONE;
      end

      pwm_next = '0;
      for (int i = 0; i < CHANNELS; i++) begin
         pwm_next[i] = enable && (cnt < a_duty[i*WIDTH +: WIDTH]);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt         <= '0;
         dir         <= DIR_UP;
         a_period    <= '0;
         a_duty      <= '0;
         a_center    <= 1'b0;
         s_period    <= '0;
         s_duty      <= '0;
         s_center    <= 1'b0;
         pending     <= 1'b0;
         pwm_out     <= '0;
         cycle_start <= 1'b0;
      end else begin
         cnt         <= cnt_next;
         dir         <= dir_next;
         pwm_out     <= pwm_next;
         cycle_start <= enable && (cnt == '0) && (dir == DIR_UP);

         if (boundary) begin
            // A strobe on the boundary cycle bypasses staging entirely
            if (update) begin
               a_period <= period;
               a_duty   <= duty;
               a_center <= center;
               s_period <= period;
               s_duty   <= duty;
               s_center <= center;
               pending  <= 1'b0;
            end else if (pending) begin
               a_period <= s_period;
               a_duty   <= s_duty;
               a_center <= s_center;
               pending  <= 1'b0;
            end
         end else if (update) begin
            s_period <= period;
            s_duty   <= duty;
            s_center <= center;
            pending  <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_pwm_multi.sv
// Testbench for pwm_multi: a reference model pushes the expected registered
// outputs of every clock edge into a queue; a monitor pops and compares them.
module tb_pwm_multi;

   localparam int W  = 16;
   localparam int CH = 4;

   logic            clk = 1'b0;
   logic            rst = 1'b1;
   logic            enable = 1'b0;
   logic [W-1:0]    period = '0;
   logic [CH*W-1:0] duty = '0;
   logic            center = 1'b0;
   logic            update = 1'b0;
   logic            pending;
   logic            cycle_start;
   logic [CH-1:0]   pwm_out;

   pwm_multi #(.WIDTH(W), .CHANNELS(CH)) dut (
      .clk         (clk),
      .rst         (rst),
      .enable      (enable),
      .period      (period),
      .duty        (duty),
      .center      (center),
      .update      (update),
      .pending     (pending),
      .cycle_start (cycle_start),
      .pwm_out     (pwm_out)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [CH-1:0] pwm;
      logic          cs;
      logic          pend;
   } exp_t;

   exp_t q[$];

   int checks = 0;
   int passes = 0;

   // Reference model: position k within the period (0..L-1)
   int mP = 0, mC = 0, sP = 0, sC = 0, mpend = 0, k = 0;
   int mD[CH];
   int sD[CH];

   int hi_cnt[CH];
   int cs_cnt = 0;

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got === exp) passes++;
      else $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
   endtask

   task automatic clear_stats();
      for (int i = 0; i < CH; i++) hi_cnt[i] = 0;
      cs_cnt = 0;
   endtask

   initial begin
      for (int i = 0; i < CH; i++) begin
         mD[i] = 0; sD[i] = 0; hi_cnt[i] = 0;
      end
      forever begin
         @(posedge clk or posedge rst);
         if (rst) begin
            mP = 0; mC = 0; sP = 0; sC = 0; mpend = 0; k = 0;
            for (int i = 0; i < CH; i++) begin
               mD[i] = 0; sD[i] = 0;
            end
            q.delete();
         end else begin
            int   len, c;
            bit   bnd;
            exp_t e;
            len = (mP <= 1) ? 1 : (mC != 0 ? 2*mP - 2 : mP);
            // center mode: position folds back down after the peak
            c = (mC != 0 && mP > 1 && k >= mP) ? (2*mP - 2 - k) : k;
            for (int i = 0; i < CH; i++) e.pwm[i] = enable && (c < mD[i]);
            e.cs = enable && (k == 0);
            bnd  = !enable || (k == len - 1);
            k    = enable ? (k + 1) % len : 0;
            if (bnd) begin
               if (update) begin
                  mP = int'(period); mC = int'(center);
                  for (int i = 0; i < CH; i++) mD[i] = int'(duty[i*W +: W]);
                  sP = mP; sC = mC; sD = mD;
                  mpend = 0;
               end else if (mpend != 0) begin
                  mP = sP; mC = sC; mD = sD;
                  mpend = 0;
               end
            end else if (update) begin
               sP = int'(period); sC = int'(center);
               for (int i = 0; i < CH; i++) sD[i] = int'(duty[i*W +: W]);
               mpend = 1;
            end
            e.pend = (mpend != 0);
            q.push_back(e);
         end
      end
   end

   initial begin
      forever begin
         @(posedge clk);
         #1;
         if (!rst) begin
            if (q.size() == 0) begin
               check("scoreboard_nonempty", 32'(q.size()), 32'd1);
            end else begin
               exp_t e;
               e = q.pop_front();
               check("cycle", 32'({pwm_out, cycle_start, pending}), 32'(e));
               for (int i = 0; i < CH; i++) hi_cnt[i] += int'(pwm_out[i]);
               cs_cnt += int'(cycle_start);
            end
         end
      end
   end

   task automatic cyc(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic strobe(input int p, input bit c, input logic [CH*W-1:0] d);
      period = p[W-1:0];
      center = c;
      duty   = d;
      update = 1'b1;
      @(negedge clk);
      update = 1'b0;
   endtask

   task automatic wait_k(input int target);
      bit found = 1'b0;
      for (int n = 0; n < 200 && !found; n++) begin
         @(negedge clk);
         if (k == target) found = 1'b1;
      end
      check("wait_phase", 32'(found), 32'd1);
   endtask

   initial begin
      cyc(3);
      check("reset_pwm", 32'(pwm_out), 32'd0);
      check("reset_pending", 32'(pending), 32'd0);
      check("reset_cs", 32'(cycle_start), 32'd0);
      rst = 1'b0;
      clear_stats();
      cyc(10);
      check("idle_hi", 32'(hi_cnt[0] + hi_cnt[1] + hi_cnt[2] + hi_cnt[3]), 32'd0);
      check("idle_cs", 32'(cs_cnt), 32'd0);

      // Edge mode, P=10
      strobe(10, 1'b0, {16'd15, 16'd10, 16'd3, 16'd0});
      enable = 1'b1;
      cyc(20);
      clear_stats();
      cyc(100);
      check("edge_hi0", 32'(hi_cnt[0]), 32'd0);
      check("edge_hi1", 32'(hi_cnt[1]), 32'd30);
      check("edge_hi2", 32'(hi_cnt[2]), 32'd100);
      check("edge_hi3", 32'(hi_cnt[3]), 32'd100);
      check("edge_cs", 32'(cs_cnt), 32'd10);

      // Center mode, P=6, duty 2 -> 10-cycle period, 3 high
      strobe(6, 1'b1, {CH{16'd2}});
      cyc(30);
      clear_stats();
      cyc(100);
      check("center_hi0", 32'(hi_cnt[0]), 32'd30);
      check("center_cs", 32'(cs_cnt), 32'd10);

      // Glitch-free update at cnt=3
      strobe(10, 1'b0, {CH{16'd5}});
      cyc(30);
      wait_k(3);
      strobe(20, 1'b0, {CH{16'd2}});
      check("staged_pending", 32'(pending), 32'd1);
      cyc(30);
      clear_stats();
      cyc(40);
      check("glitch_hi0", 32'(hi_cnt[0]), 32'd4);

      // Strobe on the boundary cycle applies directly
      wait_k(19);
      strobe(8, 1'b0, {CH{16'd3}});
      check("coincident_pending", 32'(pending), 32'd0);
      cyc(16);
      clear_stats();
      cyc(16);
      check("coincident_hi0", 32'(hi_cnt[0]), 32'd6);

      // Two strobes in one period: last wins
      wait_k(1);
      strobe(12, 1'b0, {CH{16'd4}});
      cyc(2);
      strobe(14, 1'b0, {CH{16'd7}});
      cyc(40);
      clear_stats();
      cyc(42);
      check("overwrite_hi0", 32'(hi_cnt[0]), 32'd21);

      // Degenerate periods
      strobe(0, 1'b0, {CH{16'd1}});
      cyc(20);
      clear_stats();
      cyc(20);
      check("p0_hi0", 32'(hi_cnt[0]), 32'd20);
      check("p0_cs", 32'(cs_cnt), 32'd20);
      strobe(1, 1'b1, {CH{16'd1}});
      cyc(5);
      clear_stats();
      cyc(20);
      check("p1_hi0", 32'(hi_cnt[0]), 32'd20);
      check("p1_cs", 32'(cs_cnt), 32'd20);

      // Disable with staged values
      strobe(30, 1'b0, {CH{16'd10}});
      cyc(40);
      wait_k(5);
      strobe(9, 1'b0, {CH{16'd4}});
      enable = 1'b0;
      @(negedge clk);
      check("disable_pwm", 32'(pwm_out), 32'd0);
      check("disable_pending", 32'(pending), 32'd0);
      enable = 1'b1;
      cyc(9);
      clear_stats();
      cyc(18);
      check("after_disable_hi0", 32'(hi_cnt[0]), 32'd8);

      // Randomized run
      for (int n = 0; n < 3000; n++) begin
         int p;
         logic [CH*W-1:0] dv;
         enable = ($urandom_range(0, 19) != 0);
         if ($urandom_range(0, 9) == 0) begin
            center = 1'($urandom_range(0, 1));
            p = $urandom_range(0, 24);
            if (center && p == 2) p = 3;
            for (int i = 0; i < CH; i++) begin
               if ($urandom_range(0, 15) == 0) dv[i*W +: W] = 16'hFFFF;
               else dv[i*W +: W] = W'($urandom_range(0, p + 2));
            end
            period = p[W-1:0];
            duty   = dv;
            update = 1'b1;
         end else begin
            update = 1'b0;
         end
         @(negedge clk);
      end
      update = 1'b0;

      // Mid-run reset
      strobe(10, 1'b0, {CH{16'd5}});
      enable = 1'b1;
      wait_k(2);
      strobe(16, 1'b0, {CH{16'd8}});
      #2;
      rst = 1'b1;
      #1;
      check("midrst_pwm", 32'(pwm_out), 32'd0);
      check("midrst_pending", 32'(pending), 32'd0);
      check("midrst_cs", 32'(cycle_start), 32'd0);
      @(negedge clk);
      enable = 1'b0;
      rst = 1'b0;
      clear_stats();
      cyc(10);
      check("post_rst_hi", 32'(hi_cnt[0] + hi_cnt[1] + hi_cnt[2] + hi_cnt[3]), 32'd0);
      check("post_rst_pending", 32'(pending), 32'd0);

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
